// File: rtl/load_queue_if.sv
// load_queue_if: bundle between the load queue and the load RS, store queue, dcache and CDB.
interface load_queue_if #(
  parameter int SQ_IDX_BITS = 3,
  parameter int TAG_BITS    = 6
);
  logic                   rs_valid;
  logic                   rs_ready;
  logic [31:0]            rs_base;
  logic [11:0]            rs_offset;
  logic [1:0]             rs_size;
  logic                   rs_unsigned;
  logic [TAG_BITS-1:0]    rs_tag;
  logic [SQ_IDX_BITS-1:0] rs_store_range;
  logic [SQ_IDX_BITS-1:0] sq_head;
  logic [SQ_IDX_BITS-1:0] sq_tail_ready;
  logic [31:0]            sq_addr;
  logic [SQ_IDX_BITS-1:0] sq_store_range;
  logic [1:0]             sq_byte_info;
  logic [31:0]            sq_value;
  logic                   sq_fwd_valid;
  logic                   dc_req_valid;
  logic [31:0]            dc_req_addr;
  logic                   dc_req_accept;
  logic                   dc_resp_valid;
  logic [31:0]            dc_resp_data;
  logic                   cdb_valid;
  logic [TAG_BITS-1:0]    cdb_tag;
  logic [31:0]            cdb_data;
  logic                   cdb_accept;
  logic                   squash;
  modport master (
    output rs_valid, rs_base, rs_offset, rs_size, rs_unsigned, rs_tag, rs_store_range,
           sq_head, sq_tail_ready, sq_value, sq_fwd_valid, dc_req_accept, dc_resp_valid,
           dc_resp_data, cdb_accept, squash,
    input  rs_ready, sq_addr, sq_store_range, sq_byte_info, dc_req_valid, dc_req_addr,
           cdb_valid, cdb_tag, cdb_data
  );
  modport slave (
    input  rs_valid, rs_base, rs_offset, rs_size, rs_unsigned, rs_tag, rs_store_range,
           sq_head, sq_tail_ready, sq_value, sq_fwd_valid, dc_req_accept, dc_resp_valid,
           dc_resp_data, cdb_accept, squash,
    output rs_ready, sq_addr, sq_store_range, sq_byte_info, dc_req_valid, dc_req_addr,
           cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/load_queue.sv
// load_queue: holds issued loads until older stores resolve, forwards from the SQ or reads
// the dcache, and returns extended results on the CDB out of order.
module load_queue #(
  parameter int LQ_LEN      = 4,
  parameter int SQ_IDX_BITS = 3,
  parameter int TAG_BITS    = 6
) (
  input logic        clock,
  input logic        reset,
  load_queue_if.slave lq
);
  localparam int IW = $clog2(LQ_LEN);
  typedef enum logic [2:0] {EMPTY, WAIT_ST, READY, MISS, WAIT_MEM, DONE} state_e;
  state_e                 st_q    [LQ_LEN];
  logic [31:0]            addr_q  [LQ_LEN];
  logic [31:0]            data_q  [LQ_LEN];
  logic [1:0]             size_q  [LQ_LEN];
  logic                   uns_q   [LQ_LEN];
  logic [TAG_BITS-1:0]    tag_q   [LQ_LEN];
  logic [SQ_IDX_BITS-1:0] range_q [LQ_LEN];
  logic                   drop_q, drop_d, req_lock_q, cdb_lock_q;
  logic [IW-1:0]          req_idx_q, cdb_idx_q;
  logic                   any_free, any_rdy, any_miss, any_wm, any_done;
  logic [IW-1:0]          free_idx, rdy_idx, miss_idx, done_idx, req_idx, out_idx;
  logic [LQ_LEN-1:0]      st_ok;
  logic                   alloc, req_fire, cdb_fire, resp_take;
  logic [31:0]            od, sh;
  logic [1:0]             oa, osz;
  logic [15:0]            oh;
  logic                   ou;
  always_comb begin
    {any_free, any_rdy, any_miss, any_wm, any_done} = '0;
    {free_idx, rdy_idx, miss_idx, done_idx} = '0;
    st_ok = '0;
    for (int i = LQ_LEN - 1; i >= 0; i--) begin
      st_ok[i] = (range_q[i] - lq.sq_head) <= (lq.sq_tail_ready - lq.sq_head);
      if (st_q[i] == EMPTY) begin any_free = 1'b1; free_idx = IW'(i); end
      if (st_q[i] == READY) begin any_rdy = 1'b1; rdy_idx = IW'(i); end
      if (st_q[i] == MISS) begin any_miss = 1'b1; miss_idx = IW'(i); end
      if (st_q[i] == DONE) begin any_done = 1'b1; done_idx = IW'(i); end
      if (st_q[i] == WAIT_MEM) any_wm = 1'b1;
    end
  end
  // a presented request or result keeps its entry until taken, even if a lower index catches up
  assign req_idx   = req_lock_q ? req_idx_q : miss_idx;
  assign out_idx   = cdb_lock_q ? cdb_idx_q : done_idx;
  assign alloc     = lq.rs_valid && any_free && !lq.squash;
  assign req_fire  = lq.dc_req_valid && lq.dc_req_accept;
  assign cdb_fire  = any_done && lq.cdb_accept;
  assign resp_take = lq.dc_resp_valid && !drop_q;
  assign drop_d    = ((drop_q || (lq.squash && any_wm)) && !lq.dc_resp_valid) || (lq.squash && req_fire);
  assign lq.rs_ready       = any_free;
  assign lq.sq_addr        = any_rdy ? addr_q[rdy_idx] : '0;
  assign lq.sq_store_range = any_rdy ? range_q[rdy_idx] : '0;
  assign lq.sq_byte_info   = any_rdy ? size_q[rdy_idx] : '0;
  assign lq.dc_req_valid   = any_miss && !any_wm && !drop_q;
  assign lq.dc_req_addr    = lq.dc_req_valid ? {addr_q[req_idx][31:2], 2'b00} : '0;
  assign od  = data_q[out_idx];
  assign oa  = addr_q[out_idx][1:0];
  assign osz = size_q[out_idx];
  assign ou  = uns_q[out_idx];
  assign sh  = od >> {oa, 3'b000};
  assign oh  = oa[1] ? od[31:16] : od[15:0];
  assign lq.cdb_valid = any_done;
  assign lq.cdb_tag   = any_done ? tag_q[out_idx] : '0;
  assign lq.cdb_data  = !any_done ? '0 :
                        osz == 2'd0 ? {{24{!ou && sh[7]}}, sh[7:0]} :
                        osz == 2'd1 ? {{16{!ou && oh[15]}}, oh} : od;
  always_ff @(posedge clock) begin
    drop_q    <= reset ? 1'b0 : drop_d;
    req_idx_q <= req_idx;
    cdb_idx_q <= out_idx;
    if (reset || lq.squash) begin
      req_lock_q <= 1'b0;
      cdb_lock_q <= 1'b0;
      for (int i = 0; i < LQ_LEN; i++) st_q[i] <= EMPTY;
    end else begin
      req_lock_q <= lq.dc_req_valid && !lq.dc_req_accept;
      cdb_lock_q <= any_done && !lq.cdb_accept;
      for (int i = 0; i < LQ_LEN; i++) begin
        if (alloc && free_idx == IW'(i)) begin
          st_q[i]    <= WAIT_ST;
          addr_q[i]  <= lq.rs_base + {{20{lq.rs_offset[11]}}, lq.rs_offset};
          size_q[i]  <= lq.rs_size;
          uns_q[i]   <= lq.rs_unsigned;
          tag_q[i]   <= lq.rs_tag;
          range_q[i] <= lq.rs_store_range;
        end
        if (st_q[i] == WAIT_ST && st_ok[i]) st_q[i] <= READY;
        if (any_rdy && rdy_idx == IW'(i)) begin
          st_q[i] <= lq.sq_fwd_valid ? DONE : MISS;
          if (lq.sq_fwd_valid) data_q[i] <= lq.sq_value;
        end
        if (req_fire && req_idx == IW'(i)) st_q[i] <= WAIT_MEM;
        if (st_q[i] == WAIT_MEM && resp_take) begin
          st_q[i]   <= DONE;
          data_q[i] <= lq.dc_resp_data;
        end
        if (cdb_fire && out_idx == IW'(i)) st_q[i] <= EMPTY;
      end
    end
  end
endmodule

// File: tb/tb_load_queue.sv
// tb_load_queue: directed scenarios plus random traffic against a behavioural load-queue model.
module tb_load_queue;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  load_queue_if #(.SQ_IDX_BITS(3), .TAG_BITS(6)) lq();
  load_queue #(.LQ_LEN(4), .SQ_IDX_BITS(3), .TAG_BITS(6)) dut (.clock(clock), .reset(reset), .lq(lq));
  always #5 clock = ~clock;

  // model: per load a stage 0 free, 1 waiting stores, 2 ready, 3 miss, 4 waiting memory, 5 done
  int          ms [4];
  logic [31:0] ma [4];
  logic [31:0] md [4];
  logic [1:0]  msz[4];
  logic        mu [4];
  logic [5:0]  mt [4];
  logic [2:0]  mr [4];
  bit          mdrop = 1'b0;
  int          lock_req = -1;
  int          lock_out = -1;
  int          e_free, e_rdy, e_miss, e_wm, e_done, e_req, e_out;
  bit          e_dcv;

  function automatic int first(int s);
    for (int i = 0; i < 4; i++) if (ms[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [31:0] extract(logic [31:0] d, logic [31:0] a, logic [1:0] sz, logic u);
    int unsigned w = sz == 2'd0 ? 8 : sz == 2'd1 ? 16 : 32;
    int unsigned s = sz == 2'd0 ? 8 * int'(a[1:0]) : sz == 2'd1 ? 16 * int'(a[1]) : 0;
    longint v = (longint'(d) >> s) & ((longint'(1) << w) - 1);
    if (!u && w < 32 && v >= (longint'(1) << (w - 1))) v -= longint'(1) << w;
    return 32'(v);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    e_free = first(0); e_rdy = first(2); e_miss = first(3); e_wm = first(4); e_done = first(5);
    e_req = lock_req >= 0 ? lock_req : e_miss;
    e_out = lock_out >= 0 ? lock_out : e_done;
    e_dcv = e_miss >= 0 && e_wm < 0 && !mdrop;
    chk("rs_ready", 32'(lq.rs_ready), 32'(e_free >= 0));
    chk("sq_addr", lq.sq_addr, e_rdy >= 0 ? ma[e_rdy] : 32'd0);
    chk("sq_store_range", 32'(lq.sq_store_range), e_rdy >= 0 ? 32'(mr[e_rdy]) : 32'd0);
    chk("sq_byte_info", 32'(lq.sq_byte_info), e_rdy >= 0 ? 32'(msz[e_rdy]) : 32'd0);
    chk("dc_req_valid", 32'(lq.dc_req_valid), 32'(e_dcv));
    chk("dc_req_addr", lq.dc_req_addr, e_dcv ? (ma[e_req] & ~32'd3) : 32'd0);
    chk("cdb_valid", 32'(lq.cdb_valid), 32'(e_done >= 0));
    chk("cdb_tag", 32'(lq.cdb_tag), e_done >= 0 ? 32'(mt[e_out]) : 32'd0);
    chk("cdb_data", lq.cdb_data, e_done >= 0 ? extract(md[e_out], ma[e_out], msz[e_out], mu[e_out]) : 32'd0);
  endtask

  task automatic model_update();
    int off;
    if (reset || lq.squash) begin
      mdrop = reset ? 1'b0 : ((mdrop || e_wm >= 0) && !lq.dc_resp_valid) || (e_dcv && lq.dc_req_accept);
      for (int i = 0; i < 4; i++) ms[i] = 0;
      lock_req = -1;
      lock_out = -1;
      return;
    end
    for (int i = 0; i < 4; i++)
      if (ms[i] == 1 && ((int'(mr[i]) - int'(lq.sq_head)) & 7) <= ((int'(lq.sq_tail_ready) - int'(lq.sq_head)) & 7))
        ms[i] = 2;
    if (e_rdy >= 0) begin
      ms[e_rdy] = lq.sq_fwd_valid ? 5 : 3;
      if (lq.sq_fwd_valid) md[e_rdy] = lq.sq_value;
    end
    if (e_dcv && lq.dc_req_accept) begin ms[e_req] = 4; lock_req = -1; end
    else lock_req = e_dcv ? e_req : -1;
    if (lq.dc_resp_valid) begin
      if (mdrop) mdrop = 1'b0;
      else if (e_wm >= 0) begin ms[e_wm] = 5; md[e_wm] = lq.dc_resp_data; end
    end
    if (e_done >= 0 && lq.cdb_accept) begin ms[e_out] = 0; lock_out = -1; end
    else lock_out = e_done >= 0 ? e_out : -1;
    if (lq.rs_valid && e_free >= 0) begin
      off = lq.rs_offset >= 12'd2048 ? int'(lq.rs_offset) - 4096 : int'(lq.rs_offset);
      ms[e_free] = 1; ma[e_free] = lq.rs_base + 32'(off);
      msz[e_free] = lq.rs_size; mu[e_free] = lq.rs_unsigned; mt[e_free] = lq.rs_tag; mr[e_free] = lq.rs_store_range;
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    lq.rs_valid = 1'b0; lq.sq_fwd_valid = 1'b0; lq.dc_req_accept = 1'b0;
    lq.dc_resp_valid = 1'b0; lq.cdb_accept = 1'b0; lq.squash = 1'b0;
  endtask

  task automatic load(logic [31:0] base, logic [11:0] off, logic [1:0] sz, logic u, logic [5:0] tag, logic [2:0] rng);
    lq.rs_valid = 1'b1; lq.rs_base = base; lq.rs_offset = off; lq.rs_size = sz;
    lq.rs_unsigned = u; lq.rs_tag = tag; lq.rs_store_range = rng;
  endtask

  task automatic chk_reset(string p);
    chk({p, "_rs_ready"}, 32'(lq.rs_ready), 32'd1);
    chk({p, "_dc_req_valid"}, 32'(lq.dc_req_valid), 32'd0);
    chk({p, "_cdb_valid"}, 32'(lq.cdb_valid), 32'd0);
    chk({p, "_sq_addr"}, lq.sq_addr, 32'd0);
    chk({p, "_sq_misc"}, 32'({lq.sq_store_range, lq.sq_byte_info}), 32'd0);
    chk({p, "_dc_req_addr"}, lq.dc_req_addr, 32'd0);
    chk({p, "_cdb_tag"}, 32'(lq.cdb_tag), 32'd0);
    chk({p, "_cdb_data"}, lq.cdb_data, 32'd0);
  endtask

  task automatic miss_byte(logic u, logic [31:0] exp);
    lq.sq_head = 3'd0; lq.sq_tail_ready = 3'd0;
    load(32'h200, 12'h003, 2'd0, u, 6'd7, 3'd0);
    step();
    lq.rs_valid = 1'b0;
    step();
    chk("miss_byte_info", 32'(lq.sq_byte_info), 32'd0);
    step();
    chk("miss_req_valid", 32'(lq.dc_req_valid), 32'd1);
    chk("miss_req_addr", lq.dc_req_addr, 32'h200);
    lq.dc_req_accept = 1'b1;
    step();
    lq.dc_req_accept = 1'b0;
    chk("miss_req_dropped", 32'(lq.dc_req_valid), 32'd0);
    lq.dc_resp_valid = 1'b1; lq.dc_resp_data = 32'h80112233;
    step();
    lq.dc_resp_valid = 1'b0;
    chk("miss_cdb_valid", 32'(lq.cdb_valid), 32'd1);
    chk("miss_cdb_data", lq.cdb_data, exp);
    lq.cdb_accept = 1'b1;
    step();
    lq.cdb_accept = 1'b0;
  endtask

  initial begin
    idle();
    load(32'd0, 12'd0, 2'd0, 1'b0, 6'd0, 3'd0);
    lq.rs_valid = 1'b0; lq.sq_head = 3'd0; lq.sq_tail_ready = 3'd0;
    lq.sq_value = 32'd0; lq.dc_resp_data = 32'd0;
    repeat (2) begin @(posedge clock); model_update(); #1; end
    reset = 1'b0;
    chk_reset("reset");

    lq.sq_head = 3'd2; lq.sq_tail_ready = 3'd2;
    load(32'h100, 12'h004, 2'd2, 1'b0, 6'd5, 3'd2);
    step();
    lq.rs_valid = 1'b0; lq.sq_fwd_valid = 1'b1; lq.sq_value = 32'hDEADBEEF;
    step();
    chk("fwd_sq_addr", lq.sq_addr, 32'h104);
    step();
    lq.sq_fwd_valid = 1'b0;
    chk("fwd_cdb_valid", 32'(lq.cdb_valid), 32'd1);
    chk("fwd_cdb_data", lq.cdb_data, 32'hDEADBEEF);
    chk("fwd_no_req", 32'(lq.dc_req_valid), 32'd0);
    lq.cdb_accept = 1'b1;
    step();
    lq.cdb_accept = 1'b0;
    chk("fwd_freed", 32'(lq.cdb_valid), 32'd0);

    miss_byte(1'b0, 32'hFFFFFF80);
    miss_byte(1'b1, 32'h00000080);

    lq.sq_head = 3'd3; lq.sq_tail_ready = 3'd4;
    load(32'h300, 12'h000, 2'd2, 1'b0, 6'd9, 3'd5);
    step();
    lq.rs_valid = 1'b0;
    repeat (2) step();
    chk("stwait_blocked", lq.sq_addr, 32'd0);
    lq.sq_tail_ready = 3'd5;
    step();
    chk("stwait_lookup", lq.sq_addr, 32'h300);
    lq.sq_fwd_valid = 1'b1; lq.sq_value = 32'h12345678;
    step();
    lq.sq_fwd_valid = 1'b0; lq.cdb_accept = 1'b1;
    step();
    lq.cdb_accept = 1'b0;
    lq.sq_head = 3'd6; lq.sq_tail_ready = 3'd0;
    load(32'h380, 12'h000, 2'd2, 1'b0, 6'd9, 3'd1);
    step();
    lq.rs_valid = 1'b0;
    repeat (3) step();
    chk("stwait_wrap_blocked", lq.sq_addr, 32'd0);
    lq.squash = 1'b1;
    step();
    lq.squash = 1'b0;

    lq.sq_head = 3'd0; lq.sq_tail_ready = 3'd0; lq.sq_fwd_valid = 1'b1; lq.sq_value = 32'hCAFE0001;
    for (int k = 0; k < 4; k++) begin
      load(32'h400 + 32'(4 * k), 12'h000, 2'd2, 1'b0, 6'(10 + k), 3'd0);
      step();
    end
    chk("fill_not_ready", 32'(lq.rs_ready), 32'd0);
    load(32'h500, 12'h000, 2'd2, 1'b0, 6'h3F, 3'd0);
    step();
    lq.rs_valid = 1'b0;
    chk("fill_still_full", 32'(lq.rs_ready), 32'd0);
    repeat (2) step();
    chk("hold_tag_a", 32'(lq.cdb_tag), 32'd10);
    repeat (3) step();
    chk("hold_valid", 32'(lq.cdb_valid), 32'd1);
    chk("hold_tag_b", 32'(lq.cdb_tag), 32'd10);
    lq.cdb_accept = 1'b1;
    step();
    chk("accept_frees", 32'(lq.rs_ready), 32'd1);
    repeat (3) step();
    lq.cdb_accept = 1'b0; lq.sq_fwd_valid = 1'b0;
    chk("drained", 32'(lq.cdb_valid), 32'd0);

    load(32'h500, 12'h000, 2'd2, 1'b0, 6'd20, 3'd0);
    step();
    lq.rs_valid = 1'b0;
    repeat (2) step();
    lq.dc_req_accept = 1'b1;
    step();
    lq.dc_req_accept = 1'b0; lq.squash = 1'b1;
    step();
    lq.squash = 1'b0;
    chk("squash_empty", 32'(lq.rs_ready), 32'd1);
    chk("squash_no_cdb", 32'(lq.cdb_valid), 32'd0);
    load(32'h600, 12'h000, 2'd2, 1'b0, 6'd21, 3'd0);
    step();
    lq.rs_valid = 1'b0;
    repeat (2) step();
    chk("drop_blocks_req", 32'(lq.dc_req_valid), 32'd0);
    lq.dc_resp_valid = 1'b1; lq.dc_resp_data = 32'hAAAAAAAA;
    step();
    lq.dc_resp_valid = 1'b0;
    chk("dropped_resp_no_cdb", 32'(lq.cdb_valid), 32'd0);
    chk("req_after_drop", 32'(lq.dc_req_valid), 32'd1);
    chk("req_after_drop_addr", lq.dc_req_addr, 32'h600);
    lq.dc_req_accept = 1'b1;
    step();
    lq.dc_req_accept = 1'b0; lq.dc_resp_valid = 1'b1; lq.dc_resp_data = 32'h11223344;
    step();
    lq.dc_resp_valid = 1'b0;
    chk("post_squash_data", lq.cdb_data, 32'h11223344);
    chk("post_squash_tag", 32'(lq.cdb_tag), 32'd21);
    lq.cdb_accept = 1'b1;
    step();
    lq.cdb_accept = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      lq.rs_valid = 1'($urandom); lq.rs_base = $urandom; lq.rs_offset = 12'($urandom);
      lq.rs_size = 2'($urandom); lq.rs_unsigned = 1'($urandom); lq.rs_tag = 6'($urandom);
      lq.rs_store_range = 3'($urandom); lq.sq_head = 3'($urandom); lq.sq_tail_ready = 3'($urandom);
      lq.sq_fwd_valid = 1'($urandom); lq.sq_value = $urandom; lq.dc_req_accept = 1'($urandom);
      lq.dc_resp_valid = (first(4) >= 0 || mdrop) ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
      lq.dc_resp_data = $urandom; lq.cdb_accept = 1'($urandom);
      lq.squash = $urandom_range(0, 63) == 0;
      step();
    end

    lq.rs_valid = 1'b1; lq.sq_fwd_valid = 1'b1; lq.dc_req_accept = 1'b1; lq.dc_resp_valid = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    chk_reset("midreset");
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_queue.md
Name: load_queue

Overview:
- Buffers issued loads between the load reservation station and the data cache.
- Holds each load until every older store has a resolved address, then queries the store queue for forwarding. On a forwarding miss it issues to the dcache.
- Returns the extracted, extended result on the CDB.
- Completion is out of order. Entries are freed on CDB acceptance.

Parameters:
LQ_LEN, 4, number of load entries
SQ_IDX_BITS, 3, store-queue index width; the ring holds SQ_LEN+1 = 2^SQ_IDX_BITS slots
TAG_BITS, 6, destination physical-register tag width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
rs_valid  in  1  load issued this cycle
rs_ready  out  1  at least one free entry
rs_base  in  32  base register value
rs_offset  in  12  immediate, sign-extended to 32
rs_size  in  2  MEM_SIZE: 0 BYTE, 1 HALF, 2 WORD, 3 DOUBLE
rs_unsigned  in  1  zero-extend result
rs_tag  in  TAG_BITS  destination tag
rs_store_range  in  SQ_IDX_BITS  SQ tail snapshot at dispatch; stores older than the load lie in [sq_head, rs_store_range)
sq_head  in  SQ_IDX_BITS  SQ head
sq_tail_ready  in  SQ_IDX_BITS  first SQ slot whose address is unresolved
sq_addr  out  32  forward lookup address
sq_store_range  out  SQ_IDX_BITS  lookup range
sq_byte_info  out  2  lookup size
sq_value  in  32  forwarded word-aligned image, same-cycle combinational
sq_fwd_valid  in  1  forward hit, same cycle
dc_req_valid  out  1  dcache read request
dc_req_addr  out  32  word-aligned address
dc_req_accept  in  1  request taken this cycle
dc_resp_valid  in  1  read data returned
dc_resp_data  in  32  word-aligned data
cdb_valid  out  1  result available
cdb_tag  out  TAG_BITS  result tag
cdb_data  out  32  result
cdb_accept  in  1  CDB consumed result
squash  in  1  flush all loads

Behaviour:
- Per-entry states:
  - EMPTY
  - WAIT_ST: older stores are unresolved.
  - READY: awaiting SQ lookup.
  - MISS: awaiting dcache request.
  - WAIT_MEM: request accepted, awaiting response.
  - DONE
- Allocation:
  - A load is accepted when rs_valid && rs_ready. It goes into the lowest-index EMPTY entry.
  - The entry stores addr = rs_base + sext(rs_offset) (mod 2^32), size, unsigned flag, tag and store_range. Its state is WAIT_ST.
  - rs_ready = any entry EMPTY, evaluated on registered state. An entry freed in the same cycle does not count.
  - rs_valid while rs_ready=0 is ignored.
- WAIT_ST to READY:
  - Transition when ((store_range - sq_head) mod 2^SQ_IDX_BITS) <= ((sq_tail_ready - sq_head) mod 2^SQ_IDX_BITS).
  - The check is made in the cycle after allocation at the earliest. An empty older range (store_range == sq_head) qualifies immediately.
- SQ lookup:
  - One lookup per cycle, to the lowest-index READY entry.
  - sq_* outputs are driven from that entry's registers. When no entry is READY, sq_* outputs are 0.
  - If sq_fwd_valid: the entry latches sq_value and goes to DONE. Otherwise it goes to MISS.
- dcache:
  - At most one outstanding request.
  - dc_req_valid = some entry is MISS and none is in WAIT_MEM. The request is for the lowest-index MISS entry; dc_req_addr = addr & ~3.
  - dc_req_valid is held with stable address until dc_req_accept, then the entry goes to WAIT_MEM.
  - On dc_resp_valid, the WAIT_MEM entry latches dc_resp_data and goes to DONE.
  - dc_resp_valid with no WAIT_MEM entry and no drop flag is ignored.
- Extraction (applied at CDB output):
  - BYTE uses bits [8*addr[1:0] +: 8].
  - HALF uses bits [16*addr[1] +: 16].
  - WORD and DOUBLE use the full word.
  - The selected field is sign-extended unless the unsigned flag is set.
- CDB:
  - The lowest-index DONE entry drives cdb_*. cdb_valid is held stable until cdb_accept.
  - On accept the entry becomes EMPTY. It is reusable from the next cycle.
  - With no DONE entry, cdb_valid, cdb_tag and cdb_data are 0.
- Simultaneous events: allocation, lookup, dcache handshake, response and CDB free all occur in the same cycle on distinct entries. No arbitration is needed between them.
- squash:
  - All entries go to EMPTY next cycle and rs_valid that cycle is ignored.
  - If a request was in WAIT_MEM, or was accepted in the squash cycle, a drop flag is set. The next dc_resp_valid is discarded and the flag is cleared.
  - dc_req_valid is 0 while the drop flag is set.
- Reset: all entries EMPTY and the drop flag is 0.
  - Outputs: rs_ready=1.
  - dc_req_valid=0, cdb_valid=0.
  - All sq_*, dc_req_addr, cdb_tag and cdb_data = 0.

Test Plan:
- Forwarding hit: base=0x100, off=0x004, WORD, sq_head=sq_tail_ready=rs_store_range=2; sq_fwd_valid=1, sq_value=0xDEADBEEF → sq_addr=0x104 at cycle 1, cdb_valid at cycle 2 with data 0xDEADBEEF, no dc_req.
- Miss with sign-extended byte: addr 0x203, BYTE signed; no forward; dc_resp_data=0x80112233 → cdb_data=0xFFFFFF80. Same with rs_unsigned=1 → 0x00000080.
- Store wait: store_range=5, sq_head=3, sq_tail_ready=4 → no lookup. Raise sq_tail_ready to 5 → lookup the next cycle. Also run store_range=1, head=6, tail_ready=0 (wrap) → stays in WAIT_ST.
- Fill LQ_LEN loads → rs_ready=0 and an extra rs_valid is dropped. Hold cdb_accept=0 → cdb_valid/tag stable. Accept → rs_ready=1 next cycle.
- Squash with an outstanding request: squash in WAIT_MEM → all entries empty. A following dc_resp_valid produces no cdb_valid. The next new miss issues dc_req normally.
- Reset asserted mid-operation with entries in every state → all outputs match reset values the next cycle.
